// File: rtl/dot_product_scheduler.sv
// dot_product_scheduler
//   Runs one dot-product job at a time on a pipelined dot-product multiplier.
//   Word pairs are popped from two input FIFOs in lock-step. The read strobe,
//   delayed by one cycle, becomes the multiplier valid. A MULT_LATENCY-deep
//   valid shift register marks when each product returns. Returned products
//   are accumulated, and one result per job is written to the output FIFO.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start, job_len           job request and its word-pair count (IDLE only)
//   busy, done, err_zero_len status: not IDLE / result written / zero-length request
//   fifo1_empty, fifo2_empty input FIFO status (standard read latency of one cycle)
//   fifo_rd_en               common read enable for both input FIFOs
//   mult_valid               multiplier done_reading strobe
//   mult_result              multiplier result_dotProduct
//   out_full, out_wr_en      output FIFO handshake
//   out_data                 output FIFO write data (running accumulator)
module dot_product_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int LEN_WIDTH    = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int MULT_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_WIDTH-1:0]    job_len,
  output logic                    busy,
  output logic                    done,
  output logic                    err_zero_len,
  input  logic                    fifo1_empty,
  input  logic                    fifo2_empty,
  output logic                    fifo_rd_en,
  output logic                    mult_valid,
  input  logic [2*DATA_WIDTH:0]   mult_result,
  input  logic                    out_full,
  output logic                    out_wr_en,
  output logic [ACC_WIDTH-1:0]    out_data
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]           state_q,    state_d;
  logic [LEN_WIDTH-1:0] len_q,      len_d;
  logic [LEN_WIDTH-1:0] issued_q,   issued_d;
  logic [LEN_WIDTH-1:0] returned_q, returned_d;
  logic [ACC_WIDTH-1:0] acc_q,      acc_d;
  logic                 err_q,      err_d;
  logic                 mult_valid_q;
  logic                 vsr_q [MULT_LATENCY];
  logic                 ret_valid;

  // Product of the word pair whose valid entered the shift register
  // MULT_LATENCY cycles ago is on mult_result now.
  assign ret_valid = vsr_q[MULT_LATENCY-1];

  assign fifo_rd_en   = (state_q == S_RUN) && !fifo1_empty && !fifo2_empty
                        && (issued_q < len_q);
  assign mult_valid   = mult_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign out_wr_en    = (state_q == S_WRITE) && !out_full;
  assign done         = out_wr_en;
  assign out_data     = acc_q;
  assign err_zero_len = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    acc_d      = acc_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (job_len == '0) begin
            err_d = 1'b1;
          end else begin
            len_d      = job_len;
            issued_d   = '0;
            returned_d = '0;
            acc_d      = '0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (fifo_rd_en) begin
          issued_d = issued_q + LEN_WIDTH'(1);
        end
        if (ret_valid) begin
          acc_d      = acc_q + {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, mult_result};
          returned_d = returned_q + LEN_WIDTH'(1);
          // The last product is folded in on the same edge that enters WRITE.
          if (returned_q + LEN_WIDTH'(1) == len_q) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!out_full) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      acc_q        <= '0;
      err_q        <= 1'b0;
      mult_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      returned_q   <= returned_d;
      acc_q        <= acc_d;
      err_q        <= err_d;
      // FIFO data appears one cycle after the read, together with this strobe.
      mult_valid_q <= fifo_rd_en;
    end
  end

  // Valid shift register tracking products in flight through the multiplier.
  generate
    for (genvar gi = 0; gi < MULT_LATENCY; gi++) begin : g_vsr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vsr_q[gi] <= 1'b0;
        end else if (gi == 0) begin
          vsr_q[gi] <= mult_valid_q;
        end else begin
          vsr_q[gi] <= vsr_q[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

endmodule

// File: doc/dot_product_scheduler.md
Name: dot_product_scheduler

Overview:
Sequencer that runs complete dot-product jobs on the pipelined dot-product multiplier. Each job covers job_len vector words. The block pops one word from each of the two input FIFOs per cycle and drives the multiplier valid strobe (done_reading). It tracks in-flight words over the fixed multiplier latency, accumulates the returned partial sums, and writes one accumulated result per job into the output FIFO under back-pressure.

Parameters:
DATA_WIDTH, 16, width of one FIFO word / multiplier input vector (packed 8-bit lanes)
LEN_WIDTH, 8, width of the job length field
ACC_WIDTH, 40, accumulator and output data width (must be >= 2*DATA_WIDTH+1)
MULT_LATENCY, 3, cycles from mult_valid high to mult_result valid

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  job request, sampled only in IDLE
job_len  in  LEN_WIDTH  number of word pairs in the job, captured with start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse in the cycle the job result is written
err_zero_len  out  1  one-cycle pulse when start is seen with job_len==0
fifo1_empty  in  1  input FIFO 1 empty
fifo2_empty  in  1  input FIFO 2 empty
fifo_rd_en  out  1  common read enable to both input FIFOs
mult_valid  out  1  drives multiplier done_reading
mult_result  in  2*DATA_WIDTH+1  multiplier result_dotProduct
out_full  in  1  output FIFO full
out_wr_en  out  1  output FIFO write enable
out_data  out  ACC_WIDTH  output FIFO write data

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; issue/return counters, valid shift register and accumulator cleared. Reset mid-job discards in-flight tokens with no write. The multiplier shares rst.
- Input FIFOs are standard (non-FWFT): data is valid the cycle after fifo_rd_en. mult_valid = fifo_rd_en registered by one cycle.
- Multiplier: mult_result is sampled in the cycle MULT_LATENCY cycles after a mult_valid-high cycle. Its startProcessing_wr is sticky and is not used; timing comes from an internal MULT_LATENCY-deep valid shift register fed by mult_valid.
- IDLE:
  - start=1, job_len!=0: capture len, clear acc and counters, go to RUN.
  - start=1, job_len==0: pulse err_zero_len, stay IDLE.
  - start while busy is ignored.
- RUN:
  - fifo_rd_en=1 iff !fifo1_empty && !fifo2_empty && issued<len. issued increments on each rd_en.
  - Both FIFOs are always read together. A one-side-empty stall holds rd_en low with no timeout.
  - On each returned-valid cycle: acc <= acc + zero-extend(mult_result), returned++.
  - When returned reaches len (including the final accumulate this cycle), go to WRITE.
- WRITE:
  - out_data holds acc.
  - If !out_full: out_wr_en=1 and done=1 for one cycle, then go to IDLE.
  - If out_full: hold with out_wr_en=0 and no timeout.
  - Exactly one write per job.
- Throughput: one word pair per cycle when both FIFOs are non-empty. Job latency = len + 1 + MULT_LATENCY cycles to WRITE, with no stalls.
- Arithmetic: unsigned. Accumulator wraps modulo 2^ACC_WIDTH, no saturation, no flag.
- Simultaneous: the last accumulate and the WRITE entry happen in the same cycle, and the accumulated value includes that product. start arriving in the same cycle WRITE returns to IDLE is ignored; it is seen next cycle.
- busy=0 only in IDLE. A new start is accepted the cycle after done.

Test Plan:
- job_len=1; FIFO1=0x0302, FIFO2=0x0504 -> one write, out_data=23 (2*4+3*5); done pulse; exactly one fifo_rd_en cycle; write 5 cycles after start.
- job_len=2; pairs {0x0302,0x0504},{0x0101,0x0A0A} -> out_data=43; two back-to-back rd_en cycles; busy high throughout.
- job_len=3; FIFO2 empty for 4 cycles mid-job -> rd_en low during the gap, no extra reads, correct sum; fifo1 not over-read.
- out_full=1 for 5 cycles at WRITE -> out_wr_en held low, out_data stable, single write when full drops, done coincident.
- start with job_len=0 -> err_zero_len pulse, busy stays 0, no reads or writes; start while busy -> ignored.
- rst asserted asynchronously mid-RUN with 2 tokens in flight -> outputs 0 immediately, no write; next job of 0xFFFF·0xFFFF, len=1 -> out_data=0x1FC02.
